// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: coin credit with refunds, internally timed phases, repeatable rinse.
// Optional feature: define WM_LID_PAUSE_EN to freeze the running phase while the lid is open.
module wm_cycle_ctrl #(
  parameter int PRICE     = 2,
  parameter int CNT_W     = 16,
  parameter int SOAK_CYC  = 40,
  parameter int WASH_CYC  = 60,
  parameter int RINSE_CYC = 30,
  parameter int SPIN_CYC  = 20,
  parameter int FILL_CYC  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lid,
  input  logic                         coin,
  input  logic                         cancel,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [1:0]                   rinse_n,
  output logic                         idle_op,
  output logic                         ready_op,
  output logic                         soak_op,
  output logic                         wash_op,
  output logic                         rinse_op,
  output logic                         spin_op,
  output logic                         water_inlet,
  output logic                         coin_rtn,
  output logic [$clog2(PRICE+1)-1:0]   rtn_cnt,
  output logic                         cycle_done,
  output logic                         paused
);

  localparam int CR_W = $clog2(PRICE + 1);
  localparam logic [CR_W-1:0]  PRICE_C    = CR_W'(PRICE);
  localparam logic [CR_W-1:0]  ONE_C      = CR_W'(1);
  localparam logic [CNT_W-1:0] SOAK_LAST  = CNT_W'(SOAK_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYC - 1);
  localparam logic [CNT_W-1:0] FILL_LIM   = CNT_W'(FILL_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CR_W-1:0]  credit_q, credit_d, credit_inc;
  logic [CNT_W-1:0] timer_q, timer_d, last_cnt;
  logic [1:0]       pass_q, pass_d, passes_q, passes_d;
  logic [CR_W-1:0]  rtn_d;
  logic             coin_rtn_d, done_d, paused_d, water_d, freeze, phase_q;

  function automatic state_t first_phase(input logic [1:0] m);
    case (m)
      2'b00:   return S_SOAK;
      2'b01:   return S_WASH;
      2'b10:   return S_RINSE;
      default: return S_SPIN;
    endcase
  endfunction

  function automatic logic is_fill_phase(input state_t s);
    return (s == S_SOAK) || (s == S_WASH) || (s == S_RINSE);
  endfunction

`ifdef WM_LID_PAUSE_EN
  assign freeze = lid;
`else
  assign freeze = 1'b0;
`endif

  assign phase_q = is_fill_phase(state_q) || (state_q == S_SPIN);

  // Terminal timer count of the phase currently running
  always_comb begin
    case (state_q)
      S_SOAK:  last_cnt = SOAK_LAST;
      S_WASH:  last_cnt = WASH_LAST;
      S_RINSE: last_cnt = RINSE_LAST;
      S_SPIN:  last_cnt = SPIN_LAST;
      default: last_cnt = '0;
    endcase
  end

  // Next-state, credit, timer and refund decisions
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = timer_q;
    pass_d     = pass_q;
    passes_d   = passes_q;
    done_d     = 1'b0;
    credit_inc = (coin && (credit_q < PRICE_C)) ? credit_q + ONE_C : credit_q;
    coin_rtn_d = coin;
    rtn_d      = coin ? ONE_C : '0;
    case (state_q)
      S_IDLE: begin
        if (cancel && (credit_inc != '0)) begin
          // A coin landing with cancel is counted first, so it is refunded with the rest
          coin_rtn_d = 1'b1;
          rtn_d      = credit_inc;
          credit_d   = '0;
        end else begin
          coin_rtn_d = coin && (credit_q == PRICE_C);
          rtn_d      = (coin && (credit_q == PRICE_C)) ? ONE_C : '0;
          credit_d   = credit_inc;
          if ((credit_inc == PRICE_C) && !lid) begin
            state_d = S_READY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_READY: begin
        if (cancel) begin
          state_d    = S_IDLE;
          credit_d   = '0;
          coin_rtn_d = 1'b1;
          rtn_d      = PRICE_C;
        end else if (start) begin
          state_d  = first_phase(mode);
          credit_d = '0;
          timer_d  = '0;
          pass_d   = 2'd0;
          passes_d = (rinse_n == 2'd0) ? 2'd1 : rinse_n;
        end else if (lid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READY;
        end
      end
      S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel && (state_q != S_SPIN)) begin
          state_d = S_SPIN;
          timer_d = '0;
        end else if (freeze) begin
          timer_d = timer_q;
        end else if (timer_q == last_cnt) begin
          timer_d = '0;
          case (state_q)
            S_SOAK:  state_d = S_WASH;
            S_WASH:  state_d = S_RINSE;
            S_RINSE: begin
              if (pass_q == (passes_q - 2'd1)) begin
                state_d = S_SPIN;
              end else begin
                pass_d = pass_q + 2'd1;
              end
            end
            S_SPIN: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        timer_d  = '0;
      end
    endcase
    paused_d = freeze && phase_q;
    water_d  = is_fill_phase(state_d) && (timer_d < FILL_LIM) && !paused_d;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      timer_q     <= '0;
      pass_q      <= 2'd0;
      passes_q    <= 2'd1;
      idle_op     <= 1'b1;
      ready_op    <= 1'b0;
      soak_op     <= 1'b0;
      wash_op     <= 1'b0;
      rinse_op    <= 1'b0;
      spin_op     <= 1'b0;
      water_inlet <= 1'b0;
      coin_rtn    <= 1'b0;
      rtn_cnt     <= '0;
      cycle_done  <= 1'b0;
      paused      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      timer_q     <= timer_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      idle_op     <= (state_d == S_IDLE);
      ready_op    <= (state_d == S_READY);
      soak_op     <= (state_d == S_SOAK);
      wash_op     <= (state_d == S_WASH);
      rinse_op    <= (state_d == S_RINSE);
      spin_op     <= (state_d == S_SPIN);
      water_inlet <= water_d;
      coin_rtn    <= coin_rtn_d;
      rtn_cnt     <= rtn_d;
      cycle_done  <= done_d;
      paused      <= paused_d;
    end
  end

endmodule

// File: doc/wm_cycle_ctrl.md
# wm_cycle_ctrl

Parametrised washing-machine cycle controller, the successor to `washing_machine_ctrl`. It adds several features:
- multi-coin pricing with refund
- internal phase timers, replacing the external `*_done` inputs
- a repeatable rinse phase
- mode-selected cycle subsets

It sits between the coin/lid/panel inputs and the motor/valve drivers, with one clock domain.

## Interface
- `PRICE`, 2: coins required to arm a cycle (≥1).
- `CNT_W`, 16: phase-timer width; every `*_CYC` parameter must be < 2^CNT_W.
- `SOAK_CYC`, 40: soak duration in clocks (≥1).
- `WASH_CYC`, 60: wash duration in clocks (≥1).
- `RINSE_CYC`, 30: duration of one rinse pass in clocks (≥1).
- `SPIN_CYC`, 20: spin duration in clocks (≥1).
- `FILL_CYC`, 8: `water_inlet` window at the start of each soak/wash/rinse pass (≤ min of those durations).

Ports:
- `clk` in 1: clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `lid` in 1: 1 = lid open.
- `coin` in 1: one coin per high cycle.
- `cancel` in 1: level, sampled each cycle.
- `start` in 1: begin cycle; honoured in READY only.
- `mode` in 2: 00 soak+wash+rinse+spin; 01 wash+rinse+spin; 10 rinse+spin; 11 spin only.
- `rinse_n` in 2: rinse passes; 0 is treated as 1.
- `idle_op`, `ready_op`, `soak_op`, `wash_op`, `rinse_op`, `spin_op` out 1 each: one-hot state indication.
- `water_inlet` out 1: fill valve.
- `coin_rtn` out 1: one-cycle refund pulse.
- `rtn_cnt` out `$clog2(PRICE+1)`: number of coins refunded; valid while `coin_rtn`=1, otherwise 0.
- `cycle_done` out 1: one-cycle pulse on SPIN→IDLE.
- `paused` out 1: lid pause active; see Configuration.

## Operation
- States: IDLE, READY, SOAK, WASH, RINSE, SPIN. All outputs are registered.
- Reset value: IDLE. `idle_op`=1; every other output 0. Credit=0, timer=0, rinse counter=0.
- **IDLE**
  - Each `coin` increments credit while credit < PRICE.
  - A coin arriving with credit == PRICE is refunded: `coin_rtn`=1, `rtn_cnt`=1.
  - Credit == PRICE and `lid`=0 → READY.
  - `cancel` with credit > 0 → refund all: `rtn_cnt`=credit, credit=0.
- **READY**
  - `lid`=1 → IDLE, credit kept.
  - `cancel` → refund PRICE, IDLE.
  - `start` → first phase of `mode`.
  - At the moment of `start`, `mode` and `rinse_n` are latched, credit is cleared, and the timer is cleared.
- **Phases**
  - The timer counts 0..X_CYC−1. At the last count the controller advances to the next phase and the timer clears.
  - RINSE repeats the latched pass count. The timer clears between passes.
  - `water_inlet`=1 while in SOAK/WASH/RINSE and timer < FILL_CYC (each pass).
  - SPIN end → IDLE with `cycle_done` pulse.
- **Run-time events**
  - `cancel` in SOAK/WASH/RINSE → SPIN (drain), timer cleared, no refund.
  - `cancel` in SPIN: ignored.
  - A `coin` in any state other than IDLE is refunded immediately (`rtn_cnt`=1).
- **Priority**
  - Priority order: cancel > start > lid.
  - In IDLE, a coin and cancel in the same cycle: the coin is counted, then the whole credit is refunded (`rtn_cnt`=credit+1, saturating at PRICE).

## Timing
- State change is visible on the clock edge after the qualifying input is sampled.
- Phase X: `X_op` is high for exactly X_CYC cycles, or RINSE_CYC×passes for RINSE.
- `start` to `*_op` of the first phase: 1 cycle.
- `coin` to `coin_rtn`: 1 cycle.
- `rst` mid-cycle: returns to IDLE immediately. No refund pulse; credit is lost.

## Configuration
- `WM_LID_PAUSE_EN` defined:
  - `lid`=1 in SOAK/WASH/RINSE/SPIN freezes the timer.
  - While frozen: `water_inlet` forced 0, `paused`=1, the `*_op` of the current phase held.
  - Closing the lid resumes on the next cycle from the frozen count.
  - `cancel` while paused still goes to SPIN, which stays paused until the lid closes.
- Undefined:
  - `lid` is ignored outside IDLE/READY.
  - `paused` is tied to 0.

## Test plan
- Reset, lid=0, PRICE=2: two coin pulses → `ready_op` 1 cycle after the second coin; a third coin → `coin_rtn`=1, `rtn_cnt`=1.
- mode=00, rinse_n=2, start → soak 40, wash 60, rinse 60, spin 20 cycles. `water_inlet` high 8 cycles at soak, at wash, and at each rinse pass. `cycle_done` pulse at end.
- One coin then cancel in IDLE → `rtn_cnt`=1. READY then cancel → `rtn_cnt`=2, `idle_op`=1.
- mode=01, cancel at wash cycle 10 → SPIN for 20 cycles, no `coin_rtn`, then IDLE.
- With `WM_LID_PAUSE_EN`: lid=1 for 15 cycles mid-wash → `paused`=1 and `water_inlet`=0; wash lasts 75 cycles total. Without the macro: still 60 cycles.
- `rst` asserted mid-rinse → all outputs at reset values asynchronously. mode=11, rinse_n=0: spin only, 20 cycles.
